frame_stream_tx: RTL and testbench
==================================

# frame_stream_tx

Transmit-side frame source for the Sobel pipeline. A host loads a grayscale frame into an internal byte buffer, then pulses `start`. The block emits the stream the Sobel filter consumes over a valid/ready byte interface:
- a 4-byte header: width LE, then height LE;
- then width*height pixel bytes in raster order.

It drives the filter's input side in test and loopback builds.

## Interface
- `DATA_BITS`, 8: pixel/byte width.
- `MAX_PIXELS`, 1024: buffer depth in bytes.
- `ADDR_BITS`, 10: buffer address width; equals $clog2(MAX_PIXELS).
- `clk_a`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  host buffer write strobe.
- `wr_addr`  in  ADDR_BITS  host write address.
- `wr_data`  in  DATA_BITS  host write byte.
- `start`  in  1  one-cycle pulse; begin a frame.
- `width`  in  16  frame width; sampled when `start` is accepted.
- `height`  in  16  frame height; sampled when `start` is accepted.
- `data_out`  out  DATA_BITS  stream byte.
- `valid_out`  out  1  `data_out` is valid.
- `ready_out`  in  1  downstream accepts; transfer when `valid_out && ready_out`.
- `busy`  out  1  frame in progress (not IDLE).
- `done`  out  1  one-cycle pulse after the last pixel transfer.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- **States: IDLE, HDR, PIX.**
- **IDLE:**
  - On `start`, latch `width`/`height` and compute a 32-bit `total = width*height`.
  - If `total == 0` or `total > MAX_PIXELS`: pulse `err` and stay in IDLE.
  - Otherwise go to HDR, clear the header index and pixel counter, and issue a buffer read of address 0.
- **HDR:** send width[7:0], width[15:8], height[7:0], height[15:8]. After byte 3 transfers, go to PIX.
- **PIX:**
  - Send buffer[0 .. total-1] in order.
  - After the transfer of index total-1, pulse `done` and return to IDLE.
- **Handshake:**
  - While `valid_out && !ready_out`, `data_out` and `valid_out` hold stable.
  - `valid_out` never drops before its byte transfers.
- **Host writes:** `wr_en` is honoured only in IDLE and ignored while `busy`, so the frame stays coherent. A write in the same cycle as an accepted `start` is honoured; the read of address 0 returns the old data.
- **`start` while `busy`:** ignored; no `err`.
- **Reset mid-frame:** the frame is abandoned and `valid_out` is 0 from the next cycle. Buffer contents are retained, not cleared.
- **Reset values:**
  - `valid_out`=0, `busy`=0, `done`=0, `err`=0, `data_out`=0, state=IDLE.
  - Counters are 0.

## Timing
- Accepted `start` at edge T: `valid_out`=1 with header byte 0 from T+1.
- Buffer read latency is 1 cycle; a prefetch/skid register hides it.
- With `ready_out` held high:
  - Header and pixels stream at 1 byte/cycle with no bubble between header byte 3 and pixel 0, or between pixels.
  - The full frame occupies cycles T+1 .. T+4+total.
- `done` is asserted the cycle after the last transfer, coincident with `busy`=0.
- A new `start` is accepted on that same cycle.
- **Backpressure:** `ready_out` may toggle arbitrarily. The stream must lose, duplicate and reorder no bytes. The prefetched byte is held while stalled.
- **Counter widths:**
  - The pixel counter is 32 bits and compared against `total`.
  - The buffer address is the counter's low ADDR_BITS bits; the range is guaranteed by the `start` check.

## Structure
- Package `sobel_stream_pkg`:
  - state enum `tx_state_t` (IDLE/HDR/PIX);
  - `HDR_BYTES = 4`.
  - The Sobel receiver's header parsing shares the same package.
- Sub-module `frame_bram`:
  - simple dual-port, write port driven by the host, read port driven by the sender, both on `clk_a`;
  - 1-cycle registered read, MAX_PIXELS × DATA_BITS.
- Top level holds the FSM, counters, and the output/skid register.

## Test plan
- **Basic frame:** load bytes 0x10..0x1B, width=4, height=3, `ready_out`=1.
  - Stream must be 04 00 03 00 10 11 … 1B on consecutive cycles.
  - `done` pulses once; `busy` falls with it.
- **Backpressure:** same frame, `ready_out` random at 50%.
  - Identical 16-byte sequence.
  - `data_out` is stable during every stall.
- **Rejects:**
  - width=0, height=5 → `err` pulse, no `valid_out`.
  - width=40, height=40 (1600 > 1024) → `err`, stays IDLE.
- **Busy guards:** `start` and `wr_en` (addr 0, data 0xFF) issued mid-frame → ignored. Frame completes unchanged; buffer[0] still 0x10 afterwards.
- **Reset mid-frame:** `rst` after 6 transfers.
  - `valid_out`=0 the next cycle.
  - A fresh `start` replays the full frame from header byte 0.
- **Back-to-back frames:** `start` on the `done` cycle. The second frame's header follows with no idle gap beyond one cycle.

Source files
------------

// File: rtl/sobel_stream_pkg.sv
// Shared definitions for the Sobel byte stream: sender FSM states and header layout.
package sobel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2
  } tx_state_t;

  localparam int HDR_BYTES = 4;

  // Header byte idx of a frame: width LE followed by height LE.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [15:0] w,
                                          input logic [15:0] h);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = h[7:0];
      default: b = h[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_bram.sv
// Frame buffer: simple dual-port RAM, host write port and sender read port,
// registered read with old-data behaviour on a same-address collision.
module frame_bram #(
  parameter int DATA_BITS  = 8,
  parameter int MAX_PIXELS = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk_a,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_q [MAX_PIXELS];
  logic [DATA_BITS-1:0] rd_data_q;

  // Write port and one-cycle registered read port; contents are never reset.
  always_ff @(posedge clk_a) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_stream_tx.sv
// Frame source for the Sobel pipeline: emits a width/height header followed by
// the buffered pixels in raster order over a valid/ready byte interface.
//
//   state | meaning
//   IDLE  | waiting for start; host may write the buffer
//   HDR   | sending the 4 header bytes (hdr_idx = byte on data_out)
//   PIX   | sending pixels (pix_cnt = index of the next pixel to load)
//
// The RAM read address always follows the next value of pix_cnt, so the RAM
// output register holds buffer[pix_cnt] whenever it is needed and doubles as
// the prefetch register; during a stall the same address is simply re-read.
module frame_stream_tx
  import sobel_stream_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int MAX_PIXELS = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk_a,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 start,
  input  logic [15:0]          width,
  input  logic [15:0]          height,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  tx_state_t            state_q, state_d;
  logic [1:0]           hdr_idx_q, hdr_idx_d;
  logic [31:0]          pix_cnt_q, pix_cnt_d;
  logic [31:0]          total_q, total_d;
  logic [15:0]          width_q, width_d;
  logic [15:0]          height_q, height_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [31:0]          total_in;
  logic                 xfer;
  logic                 ram_wr_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;

  assign total_in  = 32'(width) * 32'(height);
  assign xfer      = valid_q && ready_out;
  assign ram_wr_en = wr_en && (state_q == IDLE);
  assign rd_addr   = pix_cnt_d[ADDR_BITS-1:0];

  frame_bram #(
    .DATA_BITS (DATA_BITS),
    .MAX_PIXELS(MAX_PIXELS),
    .ADDR_BITS (ADDR_BITS)
  ) u_bram (
    .clk_a  (clk_a),
    .wr_en  (ram_wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Next-state, counters and output register; the output only advances on a transfer.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    pix_cnt_d = pix_cnt_q;
    total_d   = total_q;
    width_d   = width_q;
    height_d  = height_q;
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (total_in == 32'd0 || total_in > 32'(MAX_PIXELS)) begin
            err_d = 1'b1;
          end else begin
            state_d   = HDR;
            width_d   = width;
            height_d  = height;
            total_d   = total_in;
            hdr_idx_d = 2'd0;
            pix_cnt_d = 32'd0;
            data_d    = DATA_BITS'(hdr_byte(2'd0, width, height));
            valid_d   = 1'b1;
          end
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
            state_d   = PIX;
            data_d    = rd_data;
            pix_cnt_d = 32'd1;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
            data_d    = DATA_BITS'(hdr_byte(hdr_idx_q + 2'd1, width_q, height_q));
          end
        end
      end
      PIX: begin
        if (xfer) begin
          if (pix_cnt_q == total_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d    = rd_data;
            pix_cnt_d = pix_cnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; the buffer is untouched by reset.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_idx_q <= 2'd0;
      pix_cnt_q <= 32'd0;
      total_q   <= 32'd0;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      pix_cnt_q <= pix_cnt_d;
      total_q   <= total_d;
      width_q   <= width_d;
      height_q  <= height_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx: reference stream built from a byte-array model of
// the buffer plus the header rule, compared against bytes captured on transfer.
module tb_frame_stream_tx;

  localparam int AB = 10;
  localparam int MP = 1024;

  logic          clk_a = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [15:0]   width = '0;
  logic [15:0]   height = '0;
  logic          ready_out = 1'b1;
  logic [7:0]    data_out;
  logic          valid_out, busy, done, err;

  frame_stream_tx #(.DATA_BITS(8), .MAX_PIXELS(MP), .ADDR_BITS(AB)) dut (
    .clk_a(clk_a), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .width(width), .height(height), .data_out(data_out),
    .valid_out(valid_out), .ready_out(ready_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_a = ~clk_a;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] mem_model [MP];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int   bp_pct = 100;
  int   stall_viol = 0;
  int   done_cnt = 0;
  int   done_busy_viol = 0;
  int   err_cnt = 0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // ready_out pattern: percentage chance of being high each cycle
  always @(posedge clk_a) begin
    #1;
    ready_out = ($urandom_range(0, 99) < bp_pct);
  end

  // Monitor: capture transfers, stall stability, done/err pulses
  always @(negedge clk_a) begin
    if (prev_stall && (valid_out !== 1'b1 || data_out !== prev_data)) stall_viol++;
    if (rst === 1'b0 && valid_out === 1'b1 && ready_out === 1'b1) got.push_back(data_out);
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_viol++;
    end
    if (err === 1'b1) err_cnt++;
    prev_stall = (rst === 1'b0 && valid_out === 1'b1 && ready_out === 1'b0);
    prev_data  = data_out;
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [7:0] val);
    wr_en = 1'b1;
    wr_addr = AB'(addr);
    wr_data = val;
    tick();
    wr_en = 1'b0;
    mem_model[addr] = val;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) host_write(i, 8'($urandom));
  endtask

  task automatic load_basic();
    for (int i = 0; i < 12; i++) host_write(i, 8'(8'h10 + i));
  endtask

  task automatic pulse_start(input int w, input int h);
    start = 1'b1;
    width = 16'(w);
    height = 16'(h);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
    end
    to = (done !== 1'b1);
  endtask

  // Expected stream for a frame: width LE, height LE, then buffer[0..w*h-1]
  task automatic append_exp(input int w, input int h);
    exp_q.push_back(8'(w % 256));
    exp_q.push_back(8'(w / 256));
    exp_q.push_back(8'(h % 256));
    exp_q.push_back(8'(h / 256));
    for (int i = 0; i < w * h; i++) exp_q.push_back(mem_model[i]);
  endtask

  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data got %h want 00", data_out); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, d0, fd;
    bit to;
    load_basic();
    bp_pct = 100;
    tick();
    got = {};
    exp_q = {};
    append_exp(4, 3);
    d0 = done_cnt;
    pulse_start(4, 3);
    n_checks++; if (valid_out !== 1'b1) $display("FAIL basic_first_valid got %b want 1", valid_out); else n_pass++;
    n_checks++; if (data_out !== 8'h04) $display("FAIL basic_first_byte got %h want 04", data_out); else n_pass++;
    wait_done(cyc, to);
    n_checks++; if (to) $display("FAIL basic_timeout got no done want done"); else n_pass++;
    n_checks++; if (cyc != 16) $display("FAIL basic_latency got %0d want 16", cyc); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (got.size() != 16) $display("FAIL basic_len got %0d want 16", got.size()); else n_pass++;
    fd = first_diff();
    n_checks++; if (fd != -1) $display("FAIL basic_stream idx %0d got %h want %h", fd, got[fd], exp_q[fd]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc, fd, sv0;
    bit to;
    sv0 = stall_viol;
    bp_pct = 50;
    got = {};
    exp_q = {};
    append_exp(4, 3);
    pulse_start(4, 3);
    wait_done(cyc, to);
    n_checks++; if (to) $display("FAIL bp_timeout got no done want done"); else n_pass++;
    n_checks++; if (got.size() != 16) $display("FAIL bp_len got %0d want 16", got.size()); else n_pass++;
    fd = first_diff();
    n_checks++; if (fd != -1) $display("FAIL bp_stream idx %0d got %h want %h", fd, got[fd], exp_q[fd]); else n_pass++;
    n_checks++; if (stall_viol != sv0) $display("FAIL bp_stall_stable got %0d violations want 0", stall_viol - sv0); else n_pass++;
    bp_pct = 100;
    tick();
  endtask

  task automatic test_rejects();
    int ws[3] = '{0, 40, 1};
    int hs[3] = '{5, 40, 1025};
    for (int k = 0; k < 3; k++) begin
      got = {};
      pulse_start(ws[k], hs[k]);
      n_checks++; if (err !== 1'b1) $display("FAIL reject%0d_err got %b want 1", k, err); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reject%0d_busy got %b want 0", k, busy); else n_pass++;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL reject%0d_valid got %b want 0", k, valid_out); else n_pass++;
      tick();
      n_checks++; if (err !== 1'b0) $display("FAIL reject%0d_err_pulse got %b want 0", k, err); else n_pass++;
      repeat (4) tick();
      n_checks++; if (got.size() != 0) $display("FAIL reject%0d_no_stream got %0d bytes want 0", k, got.size()); else n_pass++;
    end
  endtask

  task automatic test_busy_guards();
    int cyc, fd, e0;
    bit to;
    load_basic();
    bp_pct = 100;
    e0 = err_cnt;
    got = {};
    exp_q = {};
    append_exp(4, 3);
    pulse_start(4, 3);
    repeat (3) tick();
    start = 1'b1;
    width = 16'd2;
    height = 16'd2;
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = 8'hFF;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done(cyc, to);
    n_checks++; if (to) $display("FAIL guard_timeout got no done want done"); else n_pass++;
    fd = first_diff();
    n_checks++; if (got.size() != 16 || fd != -1) $display("FAIL guard_stream len %0d idx %0d want len 16 no diff", got.size(), fd); else n_pass++;
    n_checks++; if (err_cnt != e0) $display("FAIL guard_no_err got %0d err pulses want 0", err_cnt - e0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL guard_idle got busy %b want 0", busy); else n_pass++;
    tick();
    got = {};
    exp_q = {};
    append_exp(1, 1);
    pulse_start(1, 1);
    wait_done(cyc, to);
    fd = first_diff();
    n_checks++; if (to || got.size() != 5 || fd != -1) $display("FAIL guard_buf0 len %0d idx %0d want 5 bytes ending %h", got.size(), fd, mem_model[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, fd, n;
    bit to;
    bp_pct = 100;
    got = {};
    pulse_start(4, 3);
    n = 0;
    while (got.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    n_checks++; if (got.size() < 6) $display("FAIL rstmid_progress got %0d bytes want 6", got.size()); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    tick();
    got = {};
    exp_q = {};
    append_exp(4, 3);
    pulse_start(4, 3);
    n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h04) $display("FAIL rstmid_restart got %b/%h want 1/04", valid_out, data_out); else n_pass++;
    wait_done(cyc, to);
    fd = first_diff();
    n_checks++; if (to || got.size() != 16 || fd != -1) $display("FAIL rstmid_replay len %0d idx %0d want 16 bytes no diff", got.size(), fd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, fd;
    bit to;
    load_random(10);
    bp_pct = 100;
    tick();
    got = {};
    exp_q = {};
    append_exp(5, 2);
    append_exp(3, 3);
    pulse_start(5, 2);
    wait_done(cyc, to);
    n_checks++; if (to) $display("FAIL b2b_first_timeout got no done want done"); else n_pass++;
    pulse_start(3, 3);
    n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h03) $display("FAIL b2b_second_hdr got %b/%h want 1/03", valid_out, data_out); else n_pass++;
    wait_done(cyc, to);
    n_checks++; if (to || cyc != 13) $display("FAIL b2b_second_latency got %0d want 13", cyc); else n_pass++;
    fd = first_diff();
    n_checks++; if (got.size() != 27 || fd != -1) $display("FAIL b2b_stream len %0d idx %0d want 27 bytes no diff", got.size(), fd); else n_pass++;
  endtask

  task automatic test_random_frames();
    int cyc, fd, w, h, sv0;
    bit to;
    for (int it = 0; it < 5; it++) begin
      w = $urandom_range(1, 32);
      h = $urandom_range(1, 32);
      if (it == 4) begin
        w = 32;
        h = 32;
      end
      load_random(w * h);
      bp_pct = (it == 4) ? 100 : $urandom_range(30, 100);
      sv0 = stall_viol;
      tick();
      got = {};
      exp_q = {};
      append_exp(w, h);
      pulse_start(w, h);
      wait_done(cyc, to);
      fd = first_diff();
      n_checks++; if (to || got.size() != exp_q.size() || fd != -1) $display("FAIL rand%0d_stream %0dx%0d len %0d want %0d idx %0d", it, w, h, got.size(), exp_q.size(), fd); else n_pass++;
      n_checks++; if (stall_viol != sv0) $display("FAIL rand%0d_stall got %0d violations want 0", it, stall_viol - sv0); else n_pass++;
      if (it == 4) begin
        n_checks++; if (cyc != 4 + MP) $display("FAIL max_frame_latency got %0d want %0d", cyc, 4 + MP); else n_pass++;
      end
    end
    bp_pct = 100;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rejects();
    test_busy_guards();
    test_reset_mid();
    test_back_to_back();
    test_random_frames();
    n_checks++; if (done_busy_viol != 0) $display("FAIL done_busy_overlap got %0d want 0", done_busy_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
